tcp_tx_app_responder: RTL and testbench
=======================================

// Module: tcp_tx_app_responder
// PURPOSE
// Stack-side end of the TCP TX application interface. Accepts tx_metadata requests
// ({length, session}) from the application kernel and answers each with one 64-bit
// tx_status word. For accepted requests it takes the packet's payload beats and forwards
// them, with a per-packet net_meta word, toward the TCP TX engine. Also serves as the
// loopback/simulation stand-in for the stack when testing application handshake logic.
// PARAMETERS
// NUM_SESSIONS   16      number of session IDs tracked; valid IDs are 0..NUM_SESSIONS-1
// TX_BUF_BYTES   65536   TX buffer credit in bytes, restored at reset
// MAX_PKT_BYTES  1460    largest legal request length in bytes
// PORTS
// aclk                        in   1    clock
// aresetn                     in   1    asynchronous active-low reset
// s_axis_tx_metadata_TVALID   in   1    request valid
// s_axis_tx_metadata_TREADY   out  1    high only in IDLE
// s_axis_tx_metadata_TDATA    in   32   [15:0] session, [31:16] length in bytes
// m_axis_tx_status_TVALID     out  1    status word valid
// m_axis_tx_status_TREADY     in   1    status accept
// m_axis_tx_status_TDATA      out  64   [15:0] sess, [31:16] len, [61:32] space, [63:62] code
// s_axis_tx_data_TVALID/TREADY/TDATA[511:0]/TKEEP[63:0]/TLAST   payload from application
// m_axis_net_data_TVALID/TREADY/TDATA[511:0]/TKEEP[63:0]/TLAST  payload to TX engine
// m_axis_net_meta_TVALID/TREADY/TDATA[31:0]                     {len, sess} per OK packet
// s_axis_session_TVALID       in   1    session table update, always accepted
// s_axis_session_TDATA        in   17   [16] open(1)/close(0), [15:0] session
// s_axis_ack_TVALID           in   1    credit return, always accepted
// s_axis_ack_TDATA            in   32   bytes freed
// err_len                     out  1    sticky: payload byte count != requested length
// pkt_count                   out  32   OK packets completed, wraps at 2^32
// BEHAVIOUR
// - Reset: all TVALIDs 0, state IDLE, session table all closed, space = TX_BUF_BYTES,
//   err_len 0, pkt_count 0; any request or packet in flight is discarded.
// - FSM: IDLE -> CHECK -> STATUS -> {DATA_FWD | DATA_DROP | IDLE}.
//   IDLE: meta TREADY=1; on handshake, latch sess/len and go to CHECK.
//   CHECK (1 cycle): code priority: sess>=NUM_SESSIONS or closed -> 1 (no connection);
//   len==0 or len>MAX_PKT_BYTES -> 3 (invalid); len>space -> 2 (no space); else 0.
//   Code 0 reserves len bytes of space in this cycle. Status is registered; TVALID rises
//   in the cycle after CHECK, so the request-to-status latency is 2 cycles.
//   STATUS: hold status TVALID/TDATA stable until TREADY. On handshake: code 0 -> DATA_FWD
//   with net_meta TVALID=1 {len,sess}; code 1 -> DATA_DROP; codes 2/3 -> IDLE (no payload).
//   DATA_FWD: s_tx_data TREADY = m_net_data TREADY; data/keep/last combinational
//   passthrough. net_meta is an independent registered stream and may complete before,
//   during or after the payload beats.
//   DATA_DROP: s_tx_data TREADY=1; beats discarded; nothing is emitted.
// - Packet end: a payload phase ends on the beat with TLAST; the byte count is ignored for
//   termination. Byte count = sum of popcount(TKEEP) over the packet; if this differs from
//   len at TLAST, set err_len. Return to IDLE after TLAST, and after the net_meta handshake
//   in DATA_FWD. On an OK packet end, pkt_count increments.
// - Space: 32-bit, space_next = space - reserve + ack. If the sum exceeds TX_BUF_BYTES,
//   the result saturates to TX_BUF_BYTES. Reserve and ack in the same cycle are both
//   applied. The status space field carries the value before the reservation, truncated
//   to 30 bits.
// - Session update: applies in the cycle after its TVALID. An update for an out-of-range
//   ID is ignored. A close during DATA_FWD does not abort the current packet.
// TESTING
// - open sess 3, meta {len=64,sess=3} -> status 2 cycles later, code 0, space 65536;
//   one full-keep beat with TLAST -> forwarded, net_meta 0x0040_0003, pkt_count=1.
// - meta for closed sess 5 -> code 1; send 2 beats with TLAST -> all accepted, none
//   forwarded, err_len set only if the byte count != len.
// - TX_BUF_BYTES=128: two len=100 requests -> code 0 then code 2; ack 100 -> a retry
//   returns code 0.
// - status TREADY held low 10 cycles -> TVALID/TDATA stable, meta TREADY stays 0.
// - len=100 with one 64-byte beat + TLAST -> packet closes, err_len=1, FSM in IDLE.
// - aresetn low mid-DATA_FWD -> all valids 0 immediately, space restored, table cleared.

Source files
------------

// File: rtl/tcp_tx_app_responder.sv
// ---------------------------------------------------------------------------
// tcp_tx_app_responder
//
// Stack-side end of the TCP TX application interface. Each tx_metadata
// request {length, session} is answered with one 64-bit tx_status word.
// Accepted requests (code 0) have their payload forwarded to the TX engine
// together with one net_meta word {len, sess}; requests on a closed or
// unknown session (code 1) have their payload consumed and dropped; invalid
// length (code 3) or insufficient buffer space (code 2) end the transaction
// at the status word. Also used as a loopback stand-in for the stack.
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   s_axis_tx_metadata_*          request in,  TDATA = {len[31:16], sess[15:0]}
//   m_axis_tx_status_*            status out,  TDATA = {code, space[29:0], len, sess}
//   s_axis_tx_data_*              payload from application (512-bit beats)
//   m_axis_net_data_*             payload to TX engine (passthrough in DATA_FWD)
//   m_axis_net_meta_*             {len, sess} per accepted packet
//   s_axis_session_*              table update, TDATA = {open, sess}
//   s_axis_ack_*                  credit return in bytes
//   err_len                       sticky payload-length mismatch flag
//   pkt_count                     accepted packets completed (wrapping)
// ---------------------------------------------------------------------------
module tcp_tx_app_responder #(
    parameter int NUM_SESSIONS  = 16,
    parameter int TX_BUF_BYTES  = 65536,
    parameter int MAX_PKT_BYTES = 1460
) (
    input  logic         aclk,
    input  logic         aresetn,

    input  logic         s_axis_tx_metadata_TVALID,
    output logic         s_axis_tx_metadata_TREADY,
    input  logic [31:0]  s_axis_tx_metadata_TDATA,

    output logic         m_axis_tx_status_TVALID,
    input  logic         m_axis_tx_status_TREADY,
    output logic [63:0]  m_axis_tx_status_TDATA,

    input  logic         s_axis_tx_data_TVALID,
    output logic         s_axis_tx_data_TREADY,
    input  logic [511:0] s_axis_tx_data_TDATA,
    input  logic [63:0]  s_axis_tx_data_TKEEP,
    input  logic         s_axis_tx_data_TLAST,

    output logic         m_axis_net_data_TVALID,
    input  logic         m_axis_net_data_TREADY,
    output logic [511:0] m_axis_net_data_TDATA,
    output logic [63:0]  m_axis_net_data_TKEEP,
    output logic         m_axis_net_data_TLAST,

    output logic         m_axis_net_meta_TVALID,
    input  logic         m_axis_net_meta_TREADY,
    output logic [31:0]  m_axis_net_meta_TDATA,

    input  logic         s_axis_session_TVALID,
    input  logic [16:0]  s_axis_session_TDATA,

    input  logic         s_axis_ack_TVALID,
    input  logic [31:0]  s_axis_ack_TDATA,

    output logic         err_len,
    output logic [31:0]  pkt_count
);

    localparam int          SESS_IDX_W = (NUM_SESSIONS > 1) ? $clog2(NUM_SESSIONS) : 1;
    localparam logic [16:0] NUM_SESS_ID = 17'(NUM_SESSIONS);
    localparam logic [31:0] BUF_BYTES   = 32'(TX_BUF_BYTES);
    localparam logic [15:0] MAX_LEN     = 16'(MAX_PKT_BYTES);

    localparam logic [1:0] CODE_OK       = 2'd0;
    localparam logic [1:0] CODE_NO_CONN  = 2'd1;
    localparam logic [1:0] CODE_NO_SPACE = 2'd2;
    localparam logic [1:0] CODE_INVALID  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        STATUS,
        DATA_FWD,
        DATA_DROP
    } state_t;

    // Credit arithmetic: remove the reservation, add the returned bytes and
    // clamp to the buffer size. A reservation never exceeds the current
    // credit, so the intermediate value cannot go negative.
    function automatic logic [31:0] sat_space(input logic [31:0] cur,
                                              input logic [31:0] rsv,
                                              input logic [31:0] add);
        logic [33:0] sum;
        sum = {2'b00, cur} - {2'b00, rsv} + {2'b00, add};
        if (sum > {2'b00, BUF_BYTES})
            return BUF_BYTES;
        return sum[31:0];
    endfunction

    function automatic logic [6:0] popcount64(input logic [63:0] keep);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < 64; i++)
            cnt = cnt + 7'(keep[i]);
        return cnt;
    endfunction

    state_t                  state;
    logic [15:0]             req_sess;
    logic [15:0]             req_len;
    logic [NUM_SESSIONS-1:0] sess_open;
    logic [31:0]             space;
    logic                    status_valid;
    logic [63:0]             status_data;
    logic                    meta_valid;
    logic [31:0]             meta_data;
    logic                    meta_done;
    logic                    last_done;
    logic [31:0]             byte_cnt;
    logic                    err_len_r;
    logic [31:0]             pkt_cnt;

    logic [1:0]              check_code;
    logic                    req_in_range;
    logic                    req_sess_open;
    logic [31:0]             reserve;
    logic [31:0]             ack_amt;
    logic [31:0]             space_next;
    logic                    fwd_active;
    logic                    drop_active;
    logic                    tx_ready;
    logic                    beat;
    logic                    beat_last;
    logic [31:0]             beat_total;
    logic                    len_mismatch;
    logic                    meta_hs;
    logic                    upd_in_range;

    // Session lookup; the table index is only meaningful when in range.
    assign req_in_range  = ({1'b0, req_sess} < NUM_SESS_ID);
    assign req_sess_open = req_in_range && sess_open[req_sess[SESS_IDX_W-1:0]];
    assign upd_in_range  = ({1'b0, s_axis_session_TDATA[15:0]} < NUM_SESS_ID);

    always_comb begin
        check_code = CODE_OK;
        if (!req_sess_open)
            check_code = CODE_NO_CONN;
        else if (req_len == 16'd0 || req_len > MAX_LEN)
            check_code = CODE_INVALID;
        else if ({16'd0, req_len} > space)
            check_code = CODE_NO_SPACE;
    end

    assign reserve    = (state == CHECK && check_code == CODE_OK) ? {16'd0, req_len} : 32'd0;
    assign ack_amt    = s_axis_ack_TVALID ? s_axis_ack_TDATA : 32'd0;
    assign space_next = sat_space(space, reserve, ack_amt);

    // Payload path: the forward phase stops accepting beats once TLAST has
    // passed, even if it is still waiting for the net_meta handshake.
    assign fwd_active   = (state == DATA_FWD) && !last_done;
    assign drop_active  = (state == DATA_DROP);
    assign tx_ready     = fwd_active ? m_axis_net_data_TREADY : drop_active;
    assign beat         = s_axis_tx_data_TVALID && tx_ready;
    assign beat_last    = beat && s_axis_tx_data_TLAST;
    assign beat_total   = byte_cnt + 32'(popcount64(s_axis_tx_data_TKEEP));
    assign len_mismatch = (beat_total != {16'd0, req_len});
    assign meta_hs      = meta_valid && m_axis_net_meta_TREADY;

    assign s_axis_tx_metadata_TREADY = (state == IDLE);
    assign s_axis_tx_data_TREADY     = tx_ready;
    assign m_axis_net_data_TVALID    = fwd_active && s_axis_tx_data_TVALID;
    assign m_axis_net_data_TDATA     = s_axis_tx_data_TDATA;
    assign m_axis_net_data_TKEEP     = s_axis_tx_data_TKEEP;
    assign m_axis_net_data_TLAST     = s_axis_tx_data_TLAST;
    assign m_axis_tx_status_TVALID   = status_valid;
    assign m_axis_tx_status_TDATA    = status_data;
    assign m_axis_net_meta_TVALID    = meta_valid;
    assign m_axis_net_meta_TDATA     = meta_data;
    assign err_len                   = err_len_r;
    assign pkt_count                 = pkt_cnt;

    // Control state: FSM, handshake valids, session table, credit, flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            status_valid <= 1'b0;
            meta_valid   <= 1'b0;
            meta_done    <= 1'b0;
            last_done    <= 1'b0;
            sess_open    <= '0;
            space        <= BUF_BYTES;
            err_len_r    <= 1'b0;
            pkt_cnt      <= 32'd0;
        end else begin
            space <= space_next;

            if (s_axis_session_TVALID && upd_in_range)
                sess_open[s_axis_session_TDATA[SESS_IDX_W-1:0]] <= s_axis_session_TDATA[16];

            case (state)
                IDLE: begin
                    if (s_axis_tx_metadata_TVALID)
                        state <= CHECK;
                end
                CHECK: begin
                    status_valid <= 1'b1;
                    state        <= STATUS;
                end
                STATUS: begin
                    if (m_axis_tx_status_TREADY) begin
                        status_valid <= 1'b0;
                        case (status_data[63:62])
                            CODE_OK: begin
                                state      <= DATA_FWD;
                                meta_valid <= 1'b1;
                                meta_done  <= 1'b0;
                                last_done  <= 1'b0;
                            end
                            CODE_NO_CONN: state <= DATA_DROP;
                            default:      state <= IDLE;
                        endcase
                    end
                end
                DATA_FWD: begin
                    if (meta_hs) begin
                        meta_valid <= 1'b0;
                        meta_done  <= 1'b1;
                    end
                    if (beat_last) begin
                        last_done <= 1'b1;
                        pkt_cnt   <= pkt_cnt + 32'd1;
                        if (len_mismatch)
                            err_len_r <= 1'b1;
                    end
                    // Leave only once both the payload and net_meta are done.
                    if ((meta_done || meta_hs) && (last_done || beat_last))
                        state <= IDLE;
                end
                DATA_DROP: begin
                    if (beat_last) begin
                        if (len_mismatch)
                            err_len_r <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers: only meaningful while the matching valid/state is set.
    always_ff @(posedge aclk) begin
        if (state == IDLE && s_axis_tx_metadata_TVALID) begin
            req_sess <= s_axis_tx_metadata_TDATA[15:0];
            req_len  <= s_axis_tx_metadata_TDATA[31:16];
        end
        // Status space field reports the credit before this request's reservation.
        if (state == CHECK)
            status_data <= {check_code, space[29:0], req_len, req_sess};
        if (state == STATUS)
            meta_data <= {req_len, req_sess};
        if (state == STATUS)
            byte_cnt <= 32'd0;
        else if (beat)
            byte_cnt <= beat_total;
    end

endmodule

// File: tb/tb_tcp_tx_app_responder.sv
module tb_tcp_tx_app_responder;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;
    logic aresetn;

    // DUT A (default parameters)
    logic         meta_valid, meta_ready;
    logic [31:0]  meta_data;
    logic         status_valid, status_ready;
    logic [63:0]  status_data;
    logic         tx_valid, tx_ready, tx_last;
    logic [511:0] tx_data;
    logic [63:0]  tx_keep;
    logic         net_valid, net_ready, net_last;
    logic [511:0] net_data;
    logic [63:0]  net_keep;
    logic         nmeta_valid, nmeta_ready;
    logic [31:0]  nmeta_data;
    logic         sess_valid;
    logic [16:0]  sess_data;
    logic         ack_valid;
    logic [31:0]  ack_data;
    logic         err_len;
    logic [31:0]  pkt_count;

    // DUT B (TX_BUF_BYTES = 128), payload side tied so packets drain at once
    logic         b_meta_valid, b_meta_ready;
    logic [31:0]  b_meta_data;
    logic         b_status_valid;
    logic [63:0]  b_status_data;
    logic         b_tx_ready, b_net_valid, b_net_last;
    logic [511:0] b_net_data;
    logic [63:0]  b_net_keep;
    logic         b_nmeta_valid;
    logic [31:0]  b_nmeta_data;
    logic         b_sess_valid;
    logic [16:0]  b_sess_data;
    logic         b_ack_valid;
    logic [31:0]  b_ack_data;
    logic         b_err_len;
    logic [31:0]  b_pkt_count;

    tcp_tx_app_responder dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tx_metadata_TVALID(meta_valid), .s_axis_tx_metadata_TREADY(meta_ready),
        .s_axis_tx_metadata_TDATA(meta_data),
        .m_axis_tx_status_TVALID(status_valid), .m_axis_tx_status_TREADY(status_ready),
        .m_axis_tx_status_TDATA(status_data),
        .s_axis_tx_data_TVALID(tx_valid), .s_axis_tx_data_TREADY(tx_ready),
        .s_axis_tx_data_TDATA(tx_data), .s_axis_tx_data_TKEEP(tx_keep),
        .s_axis_tx_data_TLAST(tx_last),
        .m_axis_net_data_TVALID(net_valid), .m_axis_net_data_TREADY(net_ready),
        .m_axis_net_data_TDATA(net_data), .m_axis_net_data_TKEEP(net_keep),
        .m_axis_net_data_TLAST(net_last),
        .m_axis_net_meta_TVALID(nmeta_valid), .m_axis_net_meta_TREADY(nmeta_ready),
        .m_axis_net_meta_TDATA(nmeta_data),
        .s_axis_session_TVALID(sess_valid), .s_axis_session_TDATA(sess_data),
        .s_axis_ack_TVALID(ack_valid), .s_axis_ack_TDATA(ack_data),
        .err_len(err_len), .pkt_count(pkt_count)
    );

    tcp_tx_app_responder #(.TX_BUF_BYTES(128)) dut_b (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tx_metadata_TVALID(b_meta_valid), .s_axis_tx_metadata_TREADY(b_meta_ready),
        .s_axis_tx_metadata_TDATA(b_meta_data),
        .m_axis_tx_status_TVALID(b_status_valid), .m_axis_tx_status_TREADY(1'b1),
        .m_axis_tx_status_TDATA(b_status_data),
        .s_axis_tx_data_TVALID(1'b1), .s_axis_tx_data_TREADY(b_tx_ready),
        .s_axis_tx_data_TDATA(512'd0), .s_axis_tx_data_TKEEP({64{1'b1}}),
        .s_axis_tx_data_TLAST(1'b1),
        .m_axis_net_data_TVALID(b_net_valid), .m_axis_net_data_TREADY(1'b1),
        .m_axis_net_data_TDATA(b_net_data), .m_axis_net_data_TKEEP(b_net_keep),
        .m_axis_net_data_TLAST(b_net_last),
        .m_axis_net_meta_TVALID(b_nmeta_valid), .m_axis_net_meta_TREADY(1'b1),
        .m_axis_net_meta_TDATA(b_nmeta_data),
        .s_axis_session_TVALID(b_sess_valid), .s_axis_session_TDATA(b_sess_data),
        .s_axis_ack_TVALID(b_ack_valid), .s_axis_ack_TDATA(b_ack_data),
        .err_len(b_err_len), .pkt_count(b_pkt_count)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [63:0]  status_q[$];
    logic [31:0]  nmeta_q[$];
    logic [511:0] net_q[$];
    logic [64:0]  netk_q[$];
    logic [63:0]  b_status_q[$];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected or missing event", name);
    endtask

    // Monitor: pop an expectation on every output handshake.
    always @(negedge aclk) begin
        if (aresetn === 1'b1) begin
            if (status_valid && status_ready) begin
                if (status_q.size() == 0) flag("status_unexpected");
                else check("status", status_data, status_q.pop_front());
            end
            if (nmeta_valid && nmeta_ready) begin
                if (nmeta_q.size() == 0) flag("net_meta_unexpected");
                else check("net_meta", nmeta_data, nmeta_q.pop_front());
            end
            if (net_valid && net_ready) begin
                if (net_q.size() == 0 || netk_q.size() == 0) flag("net_data_unexpected");
                else begin
                    check("net_data", net_data, net_q.pop_front());
                    check("net_keep_last", {net_last, net_keep}, netk_q.pop_front());
                end
            end
            if (b_status_valid) begin
                if (b_status_q.size() == 0) flag("b_status_unexpected");
                else check("b_status", b_status_data, b_status_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic meta_req(input logic [15:0] len, input logic [15:0] sess);
        logic hs;
        int n;
        n = 0;
        meta_valid = 1'b1;
        meta_data  = {len, sess};
        do begin
            @(negedge aclk);
            hs = meta_ready;
            tick();
            n++;
        end while (!hs && n < 100);
        if (!hs) flag("meta_timeout");
        meta_valid = 1'b0;
    endtask

    task automatic meta_req_b(input logic [15:0] len, input logic [15:0] sess);
        logic hs;
        int n;
        n = 0;
        b_meta_valid = 1'b1;
        b_meta_data  = {len, sess};
        do begin
            @(negedge aclk);
            hs = b_meta_ready;
            tick();
            n++;
        end while (!hs && n < 100);
        if (!hs) flag("b_meta_timeout");
        b_meta_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                             input logic fwd);
        logic hs;
        int n;
        n = 0;
        if (fwd) begin
            net_q.push_back(d);
            netk_q.push_back({l, k});
        end
        tx_valid = 1'b1;
        tx_data  = d;
        tx_keep  = k;
        tx_last  = l;
        do begin
            @(negedge aclk);
            hs = tx_ready;
            tick();
            n++;
        end while (!hs && n < 100);
        if (!hs) flag("beat_timeout");
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge aclk);
        while (!meta_ready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (!meta_ready) flag("idle_timeout");
        tick();
    endtask

    task automatic wait_idle_b();
        int n;
        n = 0;
        @(negedge aclk);
        while (!b_meta_ready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (!b_meta_ready) flag("b_idle_timeout");
        tick();
    endtask

    task automatic session(input logic open, input logic [15:0] sess, input logic to_b);
        if (to_b) begin b_sess_valid = 1'b1; b_sess_data = {open, sess}; end
        else      begin sess_valid   = 1'b1; sess_data   = {open, sess}; end
        tick();
        sess_valid   = 1'b0;
        b_sess_valid = 1'b0;
    endtask

    task automatic ack(input logic [31:0] bytes, input logic to_b);
        if (to_b) begin b_ack_valid = 1'b1; b_ack_data = bytes; end
        else      begin ack_valid   = 1'b1; ack_data   = bytes; end
        tick();
        ack_valid   = 1'b0;
        b_ack_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0]  FULL = {64{1'b1}};
    localparam logic [511:0] PAT0 = {8{64'h0123_4567_89AB_CDEF}};
    localparam logic [511:0] PAT1 = {16{32'hDEAD_BEEF}};
    localparam logic [511:0] PAT2 = {64{8'h5A}};

    initial begin
        logic [63:0] hold_word;
        aresetn = 1'b0;
        meta_valid = 0; meta_data = '0; status_ready = 1'b1;
        tx_valid = 0; tx_data = '0; tx_keep = '0; tx_last = 0;
        net_ready = 1'b1; nmeta_ready = 1'b1;
        sess_valid = 0; sess_data = '0; ack_valid = 0; ack_data = '0;
        b_meta_valid = 0; b_meta_data = '0; b_sess_valid = 0; b_sess_data = '0;
        b_ack_valid = 0; b_ack_data = '0;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();

        // Reset state
        check("rst_status_valid", status_valid, 1'b0);
        check("rst_net_meta_valid", nmeta_valid, 1'b0);
        check("rst_net_valid", net_valid, 1'b0);
        check("rst_meta_ready", meta_ready, 1'b1);
        check("rst_err_len", err_len, 1'b0);
        check("rst_pkt_count", pkt_count, 32'd0);

        // Open session 3, 64-byte packet, net_meta completes after the payload
        session(1'b1, 16'd3, 1'b0);
        nmeta_ready = 1'b0;
        status_q.push_back(64'h0001_0000_0040_0003);
        nmeta_q.push_back(32'h0040_0003);
        meta_req(16'd64, 16'd3);
        @(negedge aclk);
        check("latency_check_cycle", status_valid, 1'b0);
        @(negedge aclk);
        check("latency_status_cycle", status_valid, 1'b1);
        send_beat(PAT0, FULL, 1'b1, 1'b1);
        repeat (2) tick();
        check("fwd_waits_meta", meta_ready, 1'b0);
        nmeta_ready = 1'b1;
        wait_idle();
        check("pkt_count_1", pkt_count, 32'd1);
        check("err_len_ok", err_len, 1'b0);

        // Closed session 5: payload dropped, 128 bytes matches length
        status_q.push_back(64'h4000_FFC0_0080_0005);
        meta_req(16'd128, 16'd5);
        send_beat(PAT1, FULL, 1'b0, 1'b0);
        send_beat(PAT1, FULL, 1'b1, 1'b0);
        wait_idle();
        check("drop_err_len", err_len, 1'b0);
        check("drop_pkt_count", pkt_count, 32'd1);

        // Status back-pressure for 10 cycles, then a short packet (64 of 100 bytes)
        status_ready = 1'b0;
        hold_word = 64'h0000_FFC0_0064_0003;
        status_q.push_back(hold_word);
        nmeta_q.push_back(32'h0064_0003);
        meta_req(16'd100, 16'd3);
        @(negedge aclk);
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check("hold_status_valid", status_valid, 1'b1);
            check("hold_status_data", status_data, hold_word);
            check("hold_meta_ready", meta_ready, 1'b0);
        end
        tick();
        status_ready = 1'b1;
        send_beat(PAT2, FULL, 1'b1, 1'b1);
        wait_idle();
        check("short_err_len", err_len, 1'b1);
        check("short_idle", meta_ready, 1'b1);

        // Invalid lengths and closed/unknown sessions
        status_q.push_back(64'hC000_FF5C_0000_0003);
        meta_req(16'd0, 16'd3);
        wait_idle();
        status_q.push_back(64'hC000_FF5C_05B5_0003);
        meta_req(16'd1461, 16'd3);
        wait_idle();
        status_q.push_back(64'h4000_FF5C_0000_0005);
        meta_req(16'd0, 16'd5);
        send_beat(PAT0, 64'd0, 1'b1, 1'b0);
        wait_idle();
        status_q.push_back(64'h4000_FF5C_0040_0014);
        meta_req(16'd64, 16'd20);
        send_beat(PAT0, FULL, 1'b1, 1'b0);
        wait_idle();

        // Credit return saturates at the buffer size
        ack(32'd1000, 1'b0);
        status_q.push_back(64'h0001_0000_0040_0003);
        nmeta_q.push_back(32'h0040_0003);
        meta_req(16'd64, 16'd3);
        send_beat(PAT1, FULL, 1'b1, 1'b1);
        wait_idle();

        // Reset in the middle of a forwarded packet
        nmeta_ready = 1'b0;
        status_q.push_back(64'h0000_FFC0_0080_0003);
        meta_req(16'd128, 16'd3);
        send_beat(PAT2, FULL, 1'b0, 1'b1);
        tx_valid = 1'b1; tx_data = PAT0; tx_keep = FULL; tx_last = 1'b1;
        #1;
        aresetn = 1'b0;
        #1;
        check("rst_mid_net_valid", net_valid, 1'b0);
        check("rst_mid_net_meta_valid", nmeta_valid, 1'b0);
        check("rst_mid_status_valid", status_valid, 1'b0);
        check("rst_mid_tx_ready", tx_ready, 1'b0);
        tx_valid = 1'b0;
        nmeta_ready = 1'b1;
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
        check("rst_mid_err_len", err_len, 1'b0);
        check("rst_mid_pkt_count", pkt_count, 32'd0);
        check("rst_mid_meta_ready", meta_ready, 1'b1);
        // Table cleared and credit restored: session 3 now closed, space full
        status_q.push_back(64'h4001_0000_0010_0003);
        meta_req(16'd16, 16'd3);
        send_beat(PAT1, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0);
        wait_idle();
        check("rst_drop_err_len", err_len, 1'b0);

        // 128-byte buffer: accept, refuse for space, accept after ack
        session(1'b1, 16'd1, 1'b1);
        b_status_q.push_back(64'h0000_0080_0064_0001);
        meta_req_b(16'd100, 16'd1);
        wait_idle_b();
        b_status_q.push_back(64'h8000_001C_0064_0001);
        meta_req_b(16'd100, 16'd1);
        wait_idle_b();
        ack(32'd100, 1'b1);
        b_status_q.push_back(64'h0000_0080_0064_0001);
        meta_req_b(16'd100, 16'd1);
        wait_idle_b();

        repeat (5) tick();
        check("status_q_drained", 32'(status_q.size()), 32'd0);
        check("net_meta_q_drained", 32'(nmeta_q.size()), 32'd0);
        check("net_q_drained", 32'(net_q.size()), 32'd0);
        check("b_status_q_drained", 32'(b_status_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
